// File: rtl/mode_switch_pkg.sv
// Shared types and constants for the mode switch controller.
package mode_switch_pkg;

  // Switch FSM states; RUN is the only state in which routing is live.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Mode indices of the engines currently attached.
  localparam int unsigned ACQ       = 0;
  localparam int unsigned SCURVE    = 1;
  localparam int unsigned SWEEP_ACQ = 2;
  localparam int unsigned ADC       = 3;

  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_RESET_CYCLES   = 4;

  // Width of a counter that must reach the larger of two terminal counts.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/mode_switch_ctrl_if.sv
// Engine-side bundle between the switch controller and the mode engines.
// Handshake: ModeData_en is a valid-only strobe; a word is transferred on
// every cycle its strobe is high, there is no ready/backpressure.
interface mode_switch_ctrl_if #(
  parameter int NUM_MODES = 4,
  parameter int DATA_W    = 16
);
  logic [NUM_MODES-1:0]        ModeStartStop;
  logic [NUM_MODES-1:0]        ModeBusy;
  logic [NUM_MODES-1:0]        ModeDone;
  logic [NUM_MODES-1:0]        ModeForceReset;
  logic [NUM_MODES*DATA_W-1:0] ModeData;
  logic [NUM_MODES-1:0]        ModeData_en;

  modport master (
    output ModeStartStop, ModeForceReset,
    input  ModeBusy, ModeDone, ModeData, ModeData_en
  );

  modport slave (
    input  ModeStartStop, ModeForceReset,
    output ModeBusy, ModeDone, ModeData, ModeData_en
  );
endinterface

// File: rtl/mode_switch_fsm.sv
// Switch sequencer: owns the committed mode, the pending mode and the
// shared quiesce/flush counter.
module mode_switch_fsm
  import mode_switch_pkg::*;
#(
  parameter int NUM_MODES      = 4,
  parameter int MODE_W         = $clog2(NUM_MODES),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [MODE_W-1:0] i_mode_select,
  input  logic              i_busy_active,
  output state_t            o_state,
  output logic [MODE_W-1:0] o_active_mode,
  output logic              o_switch_start,
  output logic              o_timeout
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, RESET_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [MODE_W-1:0] r_pending;
  logic [MODE_W-1:0] r_active;
  logic              r_timeout;
  logic              w_start;
  logic              w_tmo_hit;
  logic              w_flush_end;

  // Next-state decode; a busy drop wins over a coincident timeout.
  always_comb begin
    w_start     = (r_state == ST_RUN) && (i_mode_select != r_active) &&
                  (int'(i_mode_select) < NUM_MODES);
    w_tmo_hit   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    w_flush_end = (r_cnt == CNT_W'(RESET_CYCLES - 1));
    w_next      = r_state;
    case (r_state)
      ST_RUN:     if (w_start) w_next = ST_QUIESCE;
      ST_QUIESCE: if (!i_busy_active || w_tmo_hit) w_next = ST_FLUSH;
      ST_FLUSH:   if (w_flush_end) w_next = ST_COMMIT;
      ST_COMMIT:  w_next = ST_RUN;
      default:    w_next = ST_RUN;
    endcase
  end

  // State, counter (restarts on every state change), pending/active mode and sticky timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_pending <= '0;
      r_active  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state != ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_start) begin
        r_pending <= i_mode_select;
        r_timeout <= 1'b0;
      end
      if ((r_state == ST_QUIESCE) && i_busy_active && w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
      if (r_state == ST_COMMIT) begin
        r_active <= r_pending;
      end
    end
  end

  assign o_state        = r_state;
  assign o_active_mode  = r_active;
  assign o_switch_start = w_start;
  assign o_timeout      = r_timeout;

endmodule

// File: rtl/mode_switch_ctrl.sv
// Registered mode switcher: routes USB start/stop, done and FIFO data to and
// from the committed engine, and sequences safe mode changes.
module mode_switch_ctrl
  import mode_switch_pkg::*;
#(
  parameter int NUM_MODES      = 4,
  parameter int MODE_W         = $clog2(NUM_MODES),
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [MODE_W-1:0]    ModeSelect,
  input  logic                 UsbStartStop,
  mode_switch_ctrl_if.master   eng,
  output logic [DATA_W-1:0]    UsbFifoData,
  output logic                 UsbFifoData_en,
  output logic                 TestDone,
  output logic [MODE_W-1:0]    ActiveMode,
  output logic                 SwitchBusy,
  output logic                 SwitchDone,
  output logic                 SwitchTimeout,
  output logic                 ModeError,
  output state_t               o_dbg_state
);

  state_t               w_state;
  logic [MODE_W-1:0]    w_active;
  logic                 w_switch_start;
  logic                 w_timeout;
  logic                 w_route;
  logic                 w_fwd;
  logic                 w_oor;
  logic [DATA_W-1:0]    w_lane;
  logic [NUM_MODES-1:0] w_force_reset;

  logic [NUM_MODES-1:0] r_start_stop;
  logic                 r_test_done;
  logic [DATA_W-1:0]    r_fifo_data;
  logic                 r_fifo_en;
  logic                 r_oor_d;
  logic                 r_mode_error;

  mode_switch_fsm #(
    .NUM_MODES      (NUM_MODES),
    .MODE_W         (MODE_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .RESET_CYCLES   (RESET_CYCLES)
  ) u_fsm (
    .i_clk          (Clk),
    .i_reset        (reset),
    .i_mode_select  (ModeSelect),
    .i_busy_active  (eng.ModeBusy[w_active]),
    .o_state        (w_state),
    .o_active_mode  (w_active),
    .o_switch_start (w_switch_start),
    .o_timeout      (w_timeout)
  );

  // Routing qualifiers; control is muted as soon as a switch is recognised,
  // while data keeps draining from the outgoing engine until FLUSH.
  always_comb begin
    w_route       = (w_state == ST_RUN) && !w_switch_start;
    w_fwd         = (w_state == ST_RUN) || (w_state == ST_QUIESCE);
    w_oor         = (int'(ModeSelect) >= NUM_MODES);
    w_lane        = eng.ModeData[int'(w_active)*DATA_W +: DATA_W];
    w_force_reset = '0;
    if (w_state == ST_FLUSH) w_force_reset[w_active] = 1'b1;
  end

  // One-cycle registered routing muxes and the out-of-range edge detector.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_start_stop <= '0;
      r_test_done  <= 1'b0;
      r_fifo_data  <= '0;
      r_fifo_en    <= 1'b0;
      r_oor_d      <= 1'b0;
      r_mode_error <= 1'b0;
    end else begin
      r_start_stop <= '0;
      if (w_route) r_start_stop[w_active] <= UsbStartStop;
      r_test_done <= w_route && eng.ModeDone[w_active];
      r_fifo_en   <= w_fwd && eng.ModeData_en[w_active];
      if (w_fwd && eng.ModeData_en[w_active]) r_fifo_data <= w_lane;
      r_oor_d      <= w_oor;
      r_mode_error <= (w_state == ST_RUN) && w_oor && !r_oor_d;
    end
  end

  assign eng.ModeStartStop  = r_start_stop;
  assign eng.ModeForceReset = w_force_reset;
  assign UsbFifoData        = r_fifo_data;
  assign UsbFifoData_en     = r_fifo_en;
  assign TestDone           = r_test_done;
  assign ActiveMode         = w_active;
  assign SwitchBusy         = (w_state != ST_RUN);
  assign SwitchDone         = (w_state == ST_COMMIT);
  assign SwitchTimeout      = w_timeout;
  assign ModeError          = r_mode_error;
  assign o_dbg_state        = w_state;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Bench for mode_switch_ctrl: random routing traffic and scripted switches
// against a timeline model of the switch sequence.
module tb_mode_switch_ctrl;
  import mode_switch_pkg::*;

  localparam int NM  = 4;
  localparam int MW  = 2;
  localparam int DW  = 16;
  localparam int TMO = 4096;
  localparam int RC  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // ---------------- main DUT ----------------
  logic [MW-1:0] mode_select = '0;
  logic          usb_ss = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_en, test_done, sw_busy, sw_done, sw_tmo, mode_err;
  logic [MW-1:0] active_mode;
  state_t        dbg_state;

  mode_switch_ctrl_if #(.NUM_MODES(NM), .DATA_W(DW)) eng();

  mode_switch_ctrl #(.NUM_MODES(NM), .MODE_W(MW), .DATA_W(DW),
                     .TIMEOUT_CYCLES(TMO), .RESET_CYCLES(RC)) dut (
    .Clk(clk), .reset(reset), .ModeSelect(mode_select), .UsbStartStop(usb_ss),
    .eng(eng), .UsbFifoData(fifo_data), .UsbFifoData_en(fifo_en),
    .TestDone(test_done), .ActiveMode(active_mode), .SwitchBusy(sw_busy),
    .SwitchDone(sw_done), .SwitchTimeout(sw_tmo), .ModeError(mode_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- three-mode DUT ----------------
  logic [MW-1:0] b_sel = '0;
  logic [DW-1:0] b_data;
  logic          b_en, b_td, b_busy, b_done, b_tmo, b_err;
  logic [MW-1:0] b_active;
  state_t        b_state;

  mode_switch_ctrl_if #(.NUM_MODES(3), .DATA_W(DW)) b_eng();

  mode_switch_ctrl #(.NUM_MODES(3), .MODE_W(MW), .DATA_W(DW),
                     .TIMEOUT_CYCLES(TMO), .RESET_CYCLES(RC)) dut_b (
    .Clk(clk), .reset(reset), .ModeSelect(b_sel), .UsbStartStop(1'b0),
    .eng(b_eng), .UsbFifoData(b_data), .UsbFifoData_en(b_en),
    .TestDone(b_td), .ActiveMode(b_active), .SwitchBusy(b_busy),
    .SwitchDone(b_done), .SwitchTimeout(b_tmo), .ModeError(b_err),
    .o_dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int m_active = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NM-1:0] onehot(input int m);
    logic [NM-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  // Monitor: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_unexpected: got word %0h with no expected word", fifo_data);
      end else begin
        check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Random strobe on a random lane; it is expected at the FIFO only if that
  // lane is one the model says is being forwarded this cycle.
  task automatic drive_data(input int fwd_a, input int fwd_b);
    int l;
    logic [DW-1:0] d;
    eng.ModeData    = {NM{DW'($urandom)}};
    eng.ModeData_en = '0;
    if ($urandom_range(0, 2) != 0) begin
      l = $urandom_range(0, NM - 1);
      d = DW'($urandom);
      eng.ModeData[l*DW +: DW] = d;
      eng.ModeData_en[l] = 1'b1;
      if (l == fwd_a || l == fwd_b) exp_q.push_back(d);
    end
  endtask

  // Steady RUN traffic in the committed mode.
  task automatic run_traffic(input int n);
    logic [NM-1:0] e_ss;
    logic          e_td;
    e_ss = '0;
    e_td = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        check("run_start_stop", 32'(eng.ModeStartStop), 32'(e_ss));
        check("run_test_done", 32'(test_done), 32'(e_td));
        check("run_active_mode", 32'(active_mode), 32'(m_active));
      end
      if (i < n) begin
        usb_ss = 1'($urandom_range(0, 1));
        eng.ModeDone = NM'($urandom);
        eng.ModeBusy = NM'($urandom);
        drive_data(m_active, -1);
        e_ss = usb_ss ? onehot(m_active) : '0;
        e_td = eng.ModeDone[m_active];
      end else begin
        usb_ss = 1'b0;
        eng.ModeData_en = '0;
      end
      @(negedge clk);
    end
  endtask

  // Switch to new_m. The outgoing engine's busy reads low from d cycles
  // after the request (never, if stuck); q is the resulting QUIESCE length.
  task automatic do_switch(input int new_m, input int d, input bit stuck);
    int old_m, q, last, n_busy, n_done, n_fr, n_fr_other, n_ss, n_td;
    old_m = m_active;
    q = stuck ? TMO : d;
    last = q + 7;
    n_busy = 0; n_done = 0; n_fr = 0; n_fr_other = 0; n_ss = 0; n_td = 0;
    mode_select = MW'(new_m);
    usb_ss = 1'b1;
    for (int i = 0; i <= last; i++) begin
      if (i >= 1) begin
        n_busy += int'(sw_busy);
        n_done += int'(sw_done);
        n_fr   += int'(eng.ModeForceReset[old_m]);
        if ((eng.ModeForceReset & ~onehot(old_m)) != '0) n_fr_other++;
        if (i <= q + 6) begin
          if (eng.ModeStartStop != '0) n_ss++;
          if (test_done) n_td++;
        end
      end
      if (i == 1) check("sw_timeout_cleared", 32'(sw_tmo), 32'(0));
      if (i == last) begin
        check("sw_start_stop_resume", 32'(eng.ModeStartStop), 32'(onehot(new_m)));
        check("sw_active_mode", 32'(active_mode), 32'(new_m));
        check("sw_timeout_flag", 32'(sw_tmo), 32'(stuck));
        check("sw_busy_cycles", 32'(n_busy), 32'(q + 5));
        check("sw_done_pulses", 32'(n_done), 32'(1));
        check("sw_force_reset_cycles", 32'(n_fr), 32'(RC));
        check("sw_force_reset_other", 32'(n_fr_other), 32'(0));
        check("sw_start_stop_quiet", 32'(n_ss), 32'(0));
        check("sw_test_done_quiet", 32'(n_td), 32'(0));
      end else begin
        eng.ModeBusy = NM'($urandom);
        eng.ModeBusy[old_m] = stuck ? 1'b1 : (i < d);
        eng.ModeDone = NM'($urandom);
        drive_data((i <= q) ? old_m : -1, (i >= q + 6) ? new_m : -1);
        @(negedge clk);
      end
    end
    m_active = new_m;
    usb_ss = 1'b0;
    eng.ModeData_en = '0;
  endtask

  // From mode 0: request 1, then 2 while the first switch is quiescing.
  task automatic do_toggle();
    int n_done, n_act1;
    n_done = 0; n_act1 = 0;
    usb_ss = 1'b0;
    eng.ModeData_en = '0;
    eng.ModeBusy = '0;
    eng.ModeBusy[0] = 1'b1;
    mode_select = 2'd1;
    for (int i = 0; i < 30; i++) begin
      if (i >= 1) begin
        n_done += int'(sw_done);
        if (active_mode == 2'd1) n_act1++;
      end
      if (i == 2) mode_select = 2'd2;
      if (i == 3) eng.ModeBusy[0] = 1'b0;
      @(negedge clk);
    end
    check("toggle_done_pulses", 32'(n_done), 32'(2));
    check("toggle_mode1_cycles", 32'(n_act1), 32'(7));
    check("toggle_active_mode", 32'(active_mode), 32'(2));
    check("toggle_switch_busy", 32'(sw_busy), 32'(0));
    m_active = 2;
  endtask

  // Reset during the second FLUSH cycle of a 2 -> 1 switch.
  task automatic do_reset_mid_flush();
    eng.ModeBusy = '0;
    eng.ModeData_en = '0;
    mode_select = 2'd1;
    for (int i = 0; i <= 4; i++) begin
      if (i == 3) begin
        check("rst_flush_force_reset", 32'(eng.ModeForceReset), 32'(onehot(m_active)));
        reset = 1'b1;
      end
      if (i == 4) begin
        check("rst_force_reset_off", 32'(eng.ModeForceReset), 32'(0));
        check("rst_active_mode", 32'(active_mode), 32'(0));
        check("rst_switch_busy", 32'(sw_busy), 32'(0));
        reset = 1'b0;
        mode_select = '0;
        m_active = 0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_err, n_bb;
    eng.ModeBusy = '0; eng.ModeDone = '0; eng.ModeData = '0; eng.ModeData_en = '0;
    b_eng.ModeBusy = '0; b_eng.ModeDone = '0; b_eng.ModeData = '0; b_eng.ModeData_en = '0;

    repeat (3) @(negedge clk);
    check("reset_start_stop", 32'(eng.ModeStartStop), 32'(0));
    check("reset_force_reset", 32'(eng.ModeForceReset), 32'(0));
    check("reset_fifo_data", 32'(fifo_data), 32'(0));
    check("reset_fifo_en", 32'(fifo_en), 32'(0));
    check("reset_test_done", 32'(test_done), 32'(0));
    check("reset_active_mode", 32'(active_mode), 32'(0));
    check("reset_switch_busy", 32'(sw_busy), 32'(0));
    check("reset_switch_done", 32'(sw_done), 32'(0));
    check("reset_timeout", 32'(sw_tmo), 32'(0));
    check("reset_mode_error", 32'(mode_err), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(ST_RUN));
    reset = 1'b0;

    // Directed first transfer in mode 0.
    usb_ss = 1'b1;
    eng.ModeData[0 +: DW] = 16'hA5A5;
    eng.ModeData_en = 4'b0001;
    exp_q.push_back(16'hA5A5);
    @(negedge clk);
    check("basic_start_stop", 32'(eng.ModeStartStop), 32'(4'b0001));
    check("basic_fifo_en", 32'(fifo_en), 32'(1));
    usb_ss = 1'b0;
    eng.ModeData_en = '0;
    @(negedge clk);

    // Out-of-range request on the three-mode instance.
    n_err = 0; n_bb = 0;
    b_sel = 2'd3;
    for (int i = 0; i < 10; i++) begin
      if (i >= 1) begin
        n_err += int'(b_err);
        n_bb  += int'(b_busy);
      end
      @(negedge clk);
    end
    check("oor_error_pulses", 32'(n_err), 32'(1));
    check("oor_switch_busy", 32'(n_bb), 32'(0));
    check("oor_active_mode", 32'(b_active), 32'(0));
    b_sel = '0;

    run_traffic(40);
    do_switch(2, 10, 1'b0);
    run_traffic(30);
    do_switch(1, 1, 1'b0);
    run_traffic(20);
    do_switch(3, 1, 1'b1);
    run_traffic(20);
    do_switch(0, 3, 1'b0);
    run_traffic(10);
    do_switch(1, TMO, 1'b0);
    do_switch(0, 2, 1'b0);
    do_toggle();
    do_reset_mid_flush();
    run_traffic(20);

    repeat (3) @(negedge clk);
    check("fifo_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
